// File: rtl/memdma_pkg.sv
// rtl/memdma_pkg.sv - shared state, mode and width definitions for memdma
package memdma_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ACC = 3'd1,
        RD_GAP = 3'd2,
        WR_ACC = 3'd3,
        WR_GAP = 3'd4,
        FIN    = 3'd5
    } state_t;

    // Words moved in one staging round: min(burst, rem)
    function automatic logic [DATA_W-1:0] round_len(input logic [DATA_W-1:0] rem, input int burst);
        return (rem > DATA_W'(burst)) ? DATA_W'(burst) : rem;
    endfunction

endpackage

// File: rtl/memdma_buf.sv
// rtl/memdma_buf.sv - staging register file, one write port and one read port
module memdma_buf
    import memdma_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/memdma.sv
// rtl/memdma.sv - single-channel copy/fill DMA master on hub bus B; fill mode built only with MEMDMA_FILL_EN
module memdma
    import memdma_pkg::*;
#(
    parameter int BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] remaining,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [1:0]        mask,
    input  logic              nwait,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam int IW = $clog2(BURST);
    localparam int CW = IW + 1;

    state_t            state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CW-1:0]     rk;
    logic [CW-1:0]     wk;
    logic [CW-1:0]     rnd_n;
    logic              ab_q;
    logic              start_fill;
    logic              fill;
    logic [DATA_W-1:0] buf_rdata;
    logic [DATA_W-1:0] wsrc;

    memdma_buf #(.DEPTH(BURST)) u_buf (
        .clk     (clk),
        .wr_en   (state == RD_ACC && nwait),
        .wr_idx  (rk[IW-1:0]),
        .wr_data (rdata),
        .rd_idx  (wk[IW-1:0]),
        .rd_data (buf_rdata)
    );

`ifdef MEMDMA_FILL_EN
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_COPY;
            fill_q <= '0;
        end else if (state == IDLE && start) begin
            mode_q <= mode;
            fill_q <= fill_data;
        end
    end

    assign start_fill = (mode == MODE_FILL);
    assign fill       = (mode_q == MODE_FILL);
    assign wsrc       = fill ? fill_q : buf_rdata;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, fill_data};
    assign start_fill = 1'b0;
    assign fill       = 1'b0;
    assign wsrc       = buf_rdata;
`endif

    // Bus strobes decode straight from state so reset drops cs at once
    assign busy    = (state != IDLE);
    assign rd      = (state == RD_ACC);
    assign wr      = (state == WR_ACC);
    assign cs      = rd | wr;
    assign mask    = 2'b00;
    assign done    = (state == FIN) && !ab_q;
    assign aborted = (state == FIN) && ab_q;
    assign addr    = rd ? src : (wr ? dst : '0);
    assign wdata   = wr ? wsrc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            rk        <= '0;
            wk        <= '0;
            rnd_n     <= '0;
            ab_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src       <= {src_addr[ADDR_W-1:1], 1'b0};
                    dst       <= {dst_addr[ADDR_W-1:1], 1'b0};
                    remaining <= len;
                    rk        <= '0;
                    wk        <= '0;
                    rnd_n     <= CW'(round_len(len, BURST));
                    ab_q      <= abort;
                    if (len == '0 || abort) state <= FIN;
                    else if (start_fill)    state <= WR_ACC;
                    else                    state <= RD_ACC;
                end
                RD_ACC: if (nwait) begin
                    src   <= src + ADDR_W'(2);
                    rk    <= rk + CW'(1);
                    state <= RD_GAP;
                end
                RD_GAP: begin
                    if (abort) begin
                        ab_q  <= 1'b1;
                        state <= FIN;
                    end else if (rk < rnd_n) begin
                        state <= RD_ACC;
                    end else begin
                        wk    <= '0;
                        state <= WR_ACC;
                    end
                end
                WR_ACC: if (nwait) begin
                    dst       <= dst + ADDR_W'(2);
                    remaining <= remaining - DATA_W'(1);
                    wk        <= wk + CW'(1);
                    state     <= WR_GAP;
                end
                WR_GAP: begin
                    // Last word written counts as normal completion even if abort is up
                    if (remaining == '0) begin
                        state <= FIN;
                    end else if (abort) begin
                        ab_q  <= 1'b1;
                        state <= FIN;
                    end else if (!fill && wk == rnd_n) begin
                        rk    <= '0;
                        rnd_n <= CW'(round_len(remaining, BURST));
                        state <= RD_ACC;
                    end else begin
                        state <= WR_ACC;
                    end
                end
                FIN: begin
                    ab_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memdma.sv
// tb/tb_memdma.sv - directed self-checking bench for memdma
module tb_memdma;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [25:0] src_addr = '0;
    logic [25:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [15:0] fill_data = '0;
    logic        abort = 1'b0;
    logic        nwait = 1'b1;
    logic [15:0] rdata = '0;
    logic        busy, done, aborted, cs, rd, wr;
    logic [15:0] remaining, wdata;
    logic [1:0]  mask;
    logic [25:0] addr;

    memdma #(.BURST(BURST)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .remaining(remaining),
        .cs(cs), .rd(rd), .wr(wr), .mask(mask), .nwait(nwait), .addr(addr),
        .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [25:0] a;
        logic [15:0] d;
        logic [15:0] rem;
    } acc_t;

    typedef struct {
        logic        m;
        logic [25:0] src;
        logic [25:0] dst;
        logic [15:0] len;
        logic [15:0] fill;
        int          wlo;
        int          whi;
        int          done_at;
    } vec_t;

    logic [15:0] mem [int];
    acc_t        log_q[$];
    acc_t        exp_q[$];
    int          wlo = 0, whi = 0, wait_left = 0;
    int          stab_viol = 0, both_viol = 0;
    logic        in_acc = 1'b0;
    logic [25:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_rd;
    logic        abort_armed = 1'b0;
    logic [25:0] abort_addr = '0;
    int          checks = 0, errors = 0;

    // Hub model: decides nwait on the falling edge, so completion is known one half-cycle early
    always @(negedge clk) begin
        if (cs) begin
            if (rd && wr) both_viol++;
            if (mask !== 2'b00) stab_viol++;
            if (!in_acc) begin
                in_acc    = 1'b1;
                acc_addr  = addr;
                acc_wdata = wdata;
                acc_rd    = rd;
                wait_left = $urandom_range(whi, wlo);
            end else if (addr !== acc_addr || wdata !== acc_wdata || rd !== acc_rd) begin
                stab_viol++;
            end
            if (wait_left > 0) begin
                nwait = 1'b0;
                wait_left--;
            end else begin
                nwait = 1'b1;
                rdata = mem.exists(int'(addr[25:1])) ? mem[int'(addr[25:1])] : 16'hDEAD;
                log_q.push_back('{wr, addr, (wr ? wdata : rdata), remaining});
                if (wr) mem[int'(addr[25:1])] = wdata;
                in_acc = 1'b0;
            end
        end else begin
            in_acc = 1'b0;
            nwait  = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int v, input int w);
        return 16'(((v * 37 + 1) * 'h0f1d) ^ (w * 'h1111) ^ 'h5a00);
    endfunction

    task automatic kick(input logic m, input logic [25:0] s, input logic [25:0] d,
                        input logic [15:0] l, input logic [15:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the first falling edge after the start-sampling edge (cycle 1)
    task automatic run(input int limit, output int done_at, output int ndone, output int nab);
        int k;
        done_at = -1; ndone = 0; nab = 0; k = 1;
        while (1) begin
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (aborted) nab++;
            if (abort_armed && cs && wr && addr == abort_addr) abort = 1'b1;
            if (!busy || k >= limit) break;
            @(negedge clk);
            k++;
        end
        check("timeout_busy", 64'(busy), 64'd0);
        abort = 1'b0;
    endtask

    vec_t vt[5];

    initial begin
        int          done_at, ndone, nab, n, rem, w, nw, cs_seen;
        logic        fillm;
        logic [25:0] s, d;
        acc_t        e;

        vt[0] = '{1'b0, 26'h100,  26'h200,  16'd3,  16'h0, 0, 0, 13};
        vt[1] = '{1'b0, 26'h1000, 26'h2000, 16'd10, 16'h0, 0, 3, -1};
        vt[2] = '{1'b0, 26'h3001, 26'h4000, 16'd8,  16'h0, 0, 0, 33};
        vt[3] = '{1'b0, 26'h10,   26'h20,   16'd1,  16'h0, 0, 0, 5};
`ifdef MEMDMA_FILL_EN
        vt[4] = '{1'b1, 26'h50,   26'h500,  16'd4,  16'hA55A, 0, 0, 9};
`else
        vt[4] = '{1'b1, 26'h50,   26'h500,  16'd4,  16'hA55A, 0, 0, 17};
`endif

        #1;
        check("rst_cs",   64'({cs, rd, wr}), 64'd0);
        check("rst_busy", 64'({busy, done, aborted}), 64'd0);
        check("rst_rem",  64'(remaining), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata_mask", 64'({wdata, mask}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
`ifdef MEMDMA_FILL_EN
            fillm = vt[i].m;
`else
            fillm = 1'b0;
`endif
            wlo = vt[i].wlo; whi = vt[i].whi;
            s = {vt[i].src[25:1], 1'b0};
            d = {vt[i].dst[25:1], 1'b0};
            for (int j = 0; j < int'(vt[i].len); j++) mem[int'(s[25:1]) + j] = pat(i, j);
            exp_q.delete();
            rem = int'(vt[i].len);
            while (rem > 0) begin
                n  = (rem > BURST) ? BURST : rem;
                nw = fillm ? rem : n;
                w  = int'(vt[i].len) - rem;
                if (!fillm) begin
                    for (int j = 0; j < n; j++) begin
                        e = '{1'b0, 26'(s + 2 * (w + j)), pat(i, w + j), 16'(rem)};
                        exp_q.push_back(e);
                    end
                end
                for (int j = 0; j < nw; j++) begin
                    e = '{1'b1, 26'(d + 2 * (w + j)), (fillm ? vt[i].fill : pat(i, w + j)), 16'(rem - j)};
                    exp_q.push_back(e);
                end
                rem -= nw;
            end
            log_q.delete();
            kick(vt[i].m, vt[i].src, vt[i].dst, vt[i].len, vt[i].fill);
            run(2000, done_at, ndone, nab);
            check($sformatf("v%0d_done_cnt", i), 64'({ndone[7:0], nab[7:0]}), 64'h0100);
            if (vt[i].done_at >= 0) check($sformatf("v%0d_done_at", i), 64'(done_at), 64'(vt[i].done_at));
            check($sformatf("v%0d_rem", i), 64'(remaining), 64'd0);
            check($sformatf("v%0d_nacc", i), 64'(log_q.size()), 64'(exp_q.size()));
            for (int j = 0; j < exp_q.size() && j < log_q.size(); j++)
                check($sformatf("v%0d_acc%0d", i, j),
                      {5'd0, log_q[j].w, log_q[j].a, log_q[j].d, log_q[j].rem},
                      {5'd0, exp_q[j].w, exp_q[j].a, exp_q[j].d, exp_q[j].rem});
        end

        // Abort during the third write's wait states
        wlo = 3; whi = 3;
        for (int j = 0; j < 5; j++) mem[int'(26'h700 >> 1) + j] = pat(9, j);
        log_q.delete();
        abort_addr = 26'h804; abort_armed = 1'b1;
        kick(1'b0, 26'h700, 26'h800, 16'd5, 16'h0);
        run(500, done_at, ndone, nab);
        abort_armed = 1'b0;
        check("abort_pulses", 64'({ndone[7:0], nab[7:0]}), 64'h0001);
        check("abort_rem", 64'(remaining), 64'd2);
        nw = 0;
        foreach (log_q[j]) if (log_q[j].w) nw++;
        check("abort_nwrites", 64'(nw), 64'd3);
        check("abort_last", 64'({log_q[log_q.size()-1].w, log_q[log_q.size()-1].a}), 64'({1'b1, 26'h804}));

        // len=0, with a second start presented during FIN
        wlo = 0; whi = 0;
        log_q.delete();
        kick(1'b0, 26'h100, 26'h200, 16'd0, 16'h0);
        check("len0_fin", 64'({busy, done, aborted, cs}), 64'b1100);
        src_addr = 26'h900; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_idle", 64'({busy, done}), 64'd0);
        cs_seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (cs || busy) cs_seen++;
        end
        check("len0_no_cs", 64'(cs_seen + log_q.size()), 64'd0);
        check("len0_rem_kept", 64'(remaining), 64'd0);

        // Destination wraps at the top of the 26-bit space
        for (int j = 0; j < 2; j++) mem[int'(26'h600 >> 1) + j] = pat(7, j);
        log_q.delete();
        kick(1'b0, 26'h600, 26'h3FFFFFE, 16'd2, 16'h0);
        run(100, done_at, ndone, nab);
        check("wrap_nacc", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            check("wrap_w0", 64'({log_q[2].w, log_q[2].a, log_q[2].d}), 64'({1'b1, 26'h3FFFFFE, pat(7, 0)}));
            check("wrap_w1", 64'({log_q[3].w, log_q[3].a, log_q[3].d}), 64'({1'b1, 26'h0, pat(7, 1)}));
        end

        // Asynchronous reset in the middle of a waited access
        wlo = 3; whi = 3;
        kick(1'b0, 26'h600, 26'h700, 16'd4, 16'h0);
        cs_seen = 0;
        for (int j = 0; j < 10 && !cs; j++) @(negedge clk);
        check("rst_mid_cs_up", 64'(cs), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_cs", 64'({cs, rd, wr, busy}), 64'd0);
        check("rst_mid_regs", 64'({addr, remaining}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_idle", 64'({busy, cs}), 64'd0);

        check("bus_stable", 64'(stab_viol), 64'd0);
        check("rd_wr_excl", 64'(both_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
